// File: rtl/decade_stopwatch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// decade_stopwatch_ctrl_pkg
// Shared definitions for the decade stopwatch controller:
//   - state_e   : controller state encoding (IDLE/RUN/PAUSE/DONE)
//   - DIGIT_W   : width of one BCD digit
//   - BCD_MAX   : highest legal BCD digit value
//   - all_nines : true when the low ndig digits of a packed BCD value are all 9
//   - is_bcd    : true when the low ndig digits of a packed value are all <= 9
// -----------------------------------------------------------------------------
package decade_stopwatch_ctrl_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Packed BCD values up to 8 digits are passed zero-extended to 32 bits.
  function automatic logic all_nines(input logic [31:0] value, input int ndig);
    logic res;
    res = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < ndig && value[i*DIGIT_W +: DIGIT_W] != BCD_MAX) begin
        res = 1'b0;
      end
    end
    return res;
  endfunction

  function automatic logic is_bcd(input logic [31:0] value, input int ndig);
    logic res;
    res = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < ndig && value[i*DIGIT_W +: DIGIT_W] > BCD_MAX) begin
        res = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decade_stopwatch_ctrl_bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One BCD decade (0..9) of the stopwatch cascade.
// Ports:
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset, digit -> 0
//   clr_i    : synchronous clear, digit -> 0 (wins over inc_i)
//   inc_i    : increment enable for this edge, 9 wraps to 0
//   q_o      : current digit value
//   carry_o  : inc_i while the digit sits at 9 (enables the next decade)
// -----------------------------------------------------------------------------
module bcd_digit
  import decade_stopwatch_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [DIGIT_W-1:0]   q_o,
  output logic                 carry_o
);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i) begin
      q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o     = q_q;
  assign carry_o = inc_i & (q_q == BCD_MAX);

endmodule

// File: rtl/decade_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// decade_stopwatch_ctrl
// Run/pause/done sequencer for a cascade of BCD decades forming a stopwatch.
// A prescaler divides clk by TICK_DIV while running; each prescaler period
// ripples one increment into the digit cascade. An optional terminal count
// (limit_i) stops the watch in DONE holding the limit value.
//
// Optional feature macro: DECADE_STOPWATCH_LAP_EN
//   When defined, adds lap_i / lap_active_o: a lap pulse in RUN freezes the
//   displayed count while the internal count keeps running; a second lap,
//   clear, reset or reaching DONE releases the freeze.
//
// Parameters:
//   DIGITS   : number of cascaded BCD digits (1..8)
//   TICK_DIV : clk cycles per count increment (>= 2)
//   PW       : prescaler width, 2**PW >= TICK_DIV
// Ports:
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset
//   start_stop_i : 1-cycle pulse, toggles run/pause (ignored in DONE)
//   clear_i      : 1-cycle pulse, zero count and return to IDLE
//   limit_en_i   : enables terminal-count compare
//   limit_i      : BCD terminal value, digit 0 in [3:0]
//   count_o      : displayed BCD count
//   tick_o       : 1-cycle pulse on every count increment
//   running_o    : high in RUN
//   done_o       : high in DONE
//   wrap_o       : 1-cycle pulse when the full count rolls 9..9 -> 0..0
// -----------------------------------------------------------------------------
module decade_stopwatch_ctrl
  import decade_stopwatch_ctrl_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000,
  parameter int PW       = 17
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_stop_i,
  input  logic                    clear_i,
  input  logic                    limit_en_i,
  input  logic [4*DIGITS-1:0]     limit_i,
`ifdef DECADE_STOPWATCH_LAP_EN
  input  logic                    lap_i,
  output logic                    lap_active_o,
`endif
  output logic [4*DIGITS-1:0]     count_o,
  output logic                    tick_o,
  output logic                    running_o,
  output logic                    done_o,
  output logic                    wrap_o
);

  localparam int             CW         = DIGIT_W * DIGITS;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  state_e          state_q;
  logic [PW-1:0]   presc_q;
  logic            tick_q;
  logic            wrap_q;
  logic            running_q;
  logic            done_q;

  logic [CW-1:0]   live_count;
  logic [CW-1:0]   count_nxt;
  logic [DIGITS:0] inc;

  logic            presc_wrap;
  logic            tick_evt;
  logic            wrap_evt;
  logic            limit_ok;
  logic            limit_hit;

  // A pending clear suppresses the increment so clear always lands on zero.
  assign presc_wrap = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
  assign tick_evt   = presc_wrap && !clear_i;
  assign inc[0]     = tick_evt;
  // The carry out of the most significant decade is exactly a full rollover.
  assign wrap_evt   = inc[DIGITS];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clear_i),
        .inc_i   (inc[gi]),
        .q_o     (live_count[gi*DIGIT_W +: DIGIT_W]),
        .carry_o (inc[gi+1])
      );

      // Post-increment value of this digit, used only by the limit compare.
      assign count_nxt[gi*DIGIT_W +: DIGIT_W] =
          !inc[gi] ? live_count[gi*DIGIT_W +: DIGIT_W] :
          (live_count[gi*DIGIT_W +: DIGIT_W] == BCD_MAX) ? '0 :
          live_count[gi*DIGIT_W +: DIGIT_W] + 4'd1;
    end
  endgenerate

  // A limit with any non-BCD digit can never equal a legal count.
  assign limit_ok  = is_bcd(32'(limit_i), DIGITS);
  assign limit_hit = tick_evt && limit_en_i && limit_ok && (count_nxt == limit_i);

`ifdef DECADE_STOPWATCH_LAP_EN
  logic          hold_q;
  logic [CW-1:0] hold_val_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef DECADE_STOPWATCH_LAP_EN
      hold_q     <= 1'b0;
      hold_val_q <= '0;
`endif
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (clear_i) begin
        state_q   <= ST_IDLE;
        presc_q   <= '0;
        running_q <= 1'b0;
        done_q    <= 1'b0;
`ifdef DECADE_STOPWATCH_LAP_EN
        hold_q    <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_stop_i) begin
              state_q   <= ST_RUN;
              presc_q   <= '0;
              running_q <= 1'b1;
            end
          end
          ST_RUN: begin
            presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
            tick_q  <= presc_wrap;
            wrap_q  <= wrap_evt;
`ifdef DECADE_STOPWATCH_LAP_EN
            // Capture the value on display at the lap edge.
            if (lap_i) begin
              hold_q <= !hold_q;
              if (!hold_q) begin
                hold_val_q <= live_count;
              end
            end
`endif
            if (limit_hit) begin
              state_q   <= ST_DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
`ifdef DECADE_STOPWATCH_LAP_EN
              hold_q    <= 1'b0;
`endif
            end else if (start_stop_i) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
            end
          end
          ST_PAUSE: begin
            // Prescaler is left untouched so the partial period resumes.
            if (start_stop_i) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_DONE: begin
            state_q <= ST_DONE;
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DECADE_STOPWATCH_LAP_EN
  assign count_o      = hold_q ? hold_val_q : live_count;
  assign lap_active_o = hold_q;
`else
  assign count_o      = live_count;
`endif

  assign tick_o    = tick_q;
  assign wrap_o    = wrap_q;
  assign running_o = running_q;
  assign done_o    = done_q;

endmodule

// File: doc/decade_stopwatch_ctrl.md
Name: decade_stopwatch_ctrl

Overview:
- Controller/sequencer for a cascade of BCD decade digits (0–9 per digit) forming a stopwatch/event timer.
- Contents: prescaler producing the count tick, run/pause/done FSM, ripple-enable logic between digits, and terminal-count compare against a programmable BCD limit.
- Sits between debounced front-panel pulses and the seven-segment display path.

Parameters:
- DIGITS, 4, number of cascaded BCD digits (1..8).
- TICK_DIV, 100000, clk cycles per count increment (>=2).
- PW, 17, prescaler width; must satisfy 2^PW >= TICK_DIV.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start_stop  input  1  single-cycle pulse; toggles run/pause.
- clear  input  1  single-cycle pulse; zero count, return to IDLE.
- limit_en  input  1  enables terminal-count compare.
- limit  input  4*DIGITS  BCD terminal value; digit 0 in bits [3:0].
- count  output  4*DIGITS  live BCD count, registered.
- tick  output  1  one-cycle pulse on each count increment.
- running  output  1  high in RUN.
- done  output  1  high in DONE (level).
- wrap  output  1  one-cycle pulse when all digits roll 9..9 -> 0..0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, count=0, prescaler=0, tick=wrap=running=done=0.
- FSM states and transitions:
  - IDLE: start_stop -> RUN, prescaler cleared.
  - RUN: start_stop -> PAUSE; limit hit -> DONE.
  - PAUSE: start_stop -> RUN. Prescaler value is kept, so a resumed partial period completes rather than restarts.
  - DONE: start_stop ignored; only clear leaves DONE.
  - clear from any state -> IDLE, count=0, prescaler=0. Takes effect the next edge.
- Priority: clear > limit hit > start_stop. If clear and start_stop arrive in the same cycle, the result is IDLE.
- Prescaler:
  - Counts only in RUN: 0..TICK_DIV-1.
  - At TICK_DIV-1 it returns to 0 and tick is registered high for one cycle. The count update lands in the same edge as tick.
  - First tick after IDLE->RUN occurs exactly TICK_DIV cycles after the start_stop edge.
- Digit cascade (on tick only):
  - Digit 0 increments with 9->0 wrap.
  - Digit n increments iff digits 0..n-1 are all 9.
  - Full overflow wraps to 0 and pulses wrap in the same cycle as tick.
  - Count never holds a non-BCD digit.
- Limit compare:
  - Evaluated on the post-increment value.
  - If limit_en and next count == limit, transition to DONE at that same edge. count holds the limit value; done=1, running=0.
  - A limit containing any digit >9 never matches.
  - limit=0 only matches after a full wrap.
  - limit/limit_en changes mid-run take effect on the next tick.
- count, tick, wrap do not change in IDLE, PAUSE, or DONE.
- Reset mid-run: immediate asynchronous clear. The first edge after release behaves as IDLE.

Optional Feature:
- Macro: DECADE_STOPWATCH_LAP_EN.
- Defined:
  - Adds input port lap (1-cycle pulse) and output lap_active (1).
  - In RUN, lap toggles a display hold. While held, count freezes at the value captured at the lap edge, and internal counting and limit compare continue.
  - A second lap releases the hold; count then shows the live value on the next cycle.
  - clear or reset releases the hold.
  - lap outside RUN is ignored.
  - DONE releases the hold so that count shows the limit.
- Undefined: no lap port; count always shows the live value.

Decomposition:
- Shared package holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3;
  - BCD_MAX=4'd9 and digit width constant 4;
  - function all_nines(value, ndig).
- One natural sub-module: bcd_digit. Ports: clk, reset, clr, inc, returns q[3:0] and carry, where carry = inc & (q==9). Instantiated DIGITS times with a generate loop.
- FSM and prescaler stay in the top.

Test Plan (DIGITS=2, TICK_DIV=4 unless noted):
- Release reset, pulse start_stop at cycle 0 -> tick at cycles 4, 8, 12; count 8'h01, 8'h02, 8'h03; running=1.
- Run to count 8'h09, then next tick -> count 8'h10, digit 1 increments once, no wrap pulse.
- Run from 8'h99 -> next tick gives count 8'h00 with wrap=1 and tick=1 in the same cycle.
- limit_en=1, limit=8'h12 -> DONE when count reaches 8'h12; further start_stop ignored. clear -> IDLE, count 8'h00.
- Pause after 2 prescaler cycles, wait 50 cycles, resume -> next tick exactly 2 cycles after resume; assert clear+start_stop together -> IDLE.
- Drop reset mid-run at count 8'h37 -> count 8'h00 asynchronously, before the next clk edge. With DECADE_STOPWATCH_LAP_EN defined: lap at 8'h05 holds the display at 8'h05 while internal counting continues; a second lap releases the hold.
